// File: rtl/adder_operand_sequencer.sv
// ============================================================================
// Module   : adder_operand_sequencer
// Purpose  : Timing/sequencing wrapper around the purely combinational 8-bit
//            ULA adder. Operand bytes arrive one at a time on a shared bus
//            (valid/ready). The block drives the adder operands a/b and the
//            adder output-buffer enable en. It registers the 9-bit adder
//            result t into res and offers res downstream with its own
//            valid/ready handshake.
//
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            in_data    - operand byte from the shared bus
//            in_valid   - in_data valid this cycle
//            in_ready   - block accepts in_data this cycle
//            a, b       - operands to the adder
//            en         - adder output-buffer enable (high only in S_ADD)
//            t          - adder result, bit 8 = carry out
//            clr        - accumulator clear (ACCUMULATE_EN builds only)
//            res        - registered 9-bit result
//            res_valid  - res is valid
//            res_ready  - downstream accepts res
//            busy       - high whenever the FSM is not in S_LOAD_A
//            op_count   - results accepted downstream, wraps mod 2^OPS_W
//
// Config   : `define ACCUMULATE_EN to feed the low byte of each accepted
//            result back as operand A. Only B bytes are then consumed per
//            operation, and clr zeroes the running sum. Without the macro,
//            clr is ignored.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_operand_sequencer #(
    parameter int OPS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       a,
    output logic [7:0]       b,
    output logic             en,
    input  logic [8:0]       t,
    input  logic             clr,
    output logic [8:0]       res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [OPS_W-1:0] op_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_ADD    = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [OPS_W-1:0] c_count_one = {{(OPS_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [8:0]       r_res;
    logic             r_res_valid;
    logic [OPS_W-1:0] r_op_count;

    // Datapath controls decoded by the next-state process
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_clr;
    logic             w_load_a;
    logic             w_load_b;
    logic             w_zero_a;
    logic             w_capture;
    logic             w_accept;
    logic             w_feedback_a;

    // ------------------------------------------------------------------------
    // Optional accumulate clear. In the plain build clr is deliberately left
    // unconnected to the control path; the named sink keeps that explicit.
    // ------------------------------------------------------------------------
`ifdef ACCUMULATE_EN
    assign w_clr = clr;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr;
    assign w_clr        = 1'b0;
`endif

    // The bus is only listened to while an operand slot is open.
    assign w_in_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_xfer     = in_valid & w_in_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_zero_a     = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_feedback_a = 1'b0;

        case (r_state)
            S_LOAD_A: begin
                // A clear wins over a byte arriving in the same cycle.
                if (w_clr) begin
                    w_zero_a = 1'b1;
                end else if (w_xfer) begin
                    w_load_a     = 1'b1;
                    w_state_next = S_LOAD_B;
                end
            end

            S_LOAD_B: begin
                // A clear drops the running sum and reopens the A slot,
                // discarding any B byte offered in the same cycle.
                if (w_clr) begin
                    w_zero_a     = 1'b1;
                    w_state_next = S_LOAD_A;
                end else if (w_xfer) begin
                    w_load_b     = 1'b1;
                    w_state_next = S_ADD;
                end
            end

            S_ADD: begin
                // The adder is combinational with en asserted this cycle,
                // so t is sampled at the edge that ends S_ADD.
                w_capture    = 1'b1;
                w_state_next = S_RESULT;
            end

            S_RESULT: begin
                if (res_ready) begin
                    w_accept = 1'b1;
`ifdef ACCUMULATE_EN
                    w_feedback_a = 1'b1;
                    w_state_next = S_LOAD_B;
`else
                    w_state_next = S_LOAD_A;
`endif
                end
            end

            default: begin
                w_state_next = S_LOAD_A;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand registers. Values persist across operations; only reset, a new
    // byte, a clear or accumulator feedback overwrite them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= 8'h00;
        end else if (w_zero_a) begin
            r_a <= 8'h00;
        end else if (w_load_a) begin
            r_a <= in_data;
        end else if (w_feedback_a) begin
            // Carry bit is not fed back; it is still visible in res.
            r_a <= r_res[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b <= 8'h00;
        end else if (w_load_b) begin
            r_b <= in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Result register and its handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= 9'h000;
        end else if (w_capture) begin
            r_res <= t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
        end else if (w_accept) begin
            r_res_valid <= 1'b0;
        end
    end

    // Completed-operation counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= {OPS_W{1'b0}};
        end else if (w_accept) begin
            r_op_count <= r_op_count + c_count_one;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign en        = (r_state == S_ADD);
    assign busy      = (r_state != S_LOAD_A);
    assign a         = r_a;
    assign b         = r_b;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_operand_sequencer.sv
// ============================================================================
// Module   : tb_adder_operand_sequencer
// Purpose  : Self-checking bench for adder_operand_sequencer. The ULA adder
//            is modelled combinationally. A reference model tracks operands,
//            outstanding results and the op counter from the byte stream.
//            Expected results are queued as B bytes are issued, and a
//            negedge monitor compares every observable output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_operand_sequencer;

    localparam int OPS_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             en;
    logic [8:0]       t;
    logic             clr;
    logic [8:0]       res;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [OPS_W-1:0] op_count;

    adder_operand_sequencer #(.OPS_W(OPS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .en        (en),
        .t         (t),
        .clr       (clr),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Combinational adder with gated output buffer
    assign t = en ? ({1'b0, a} + {1'b0, b}) : 9'h000;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         started  = 1'b0;
    bit         outstanding = 1'b0;   // result issued but not yet accepted
    bit         have_a   = 1'b0;      // operand A loaded (or running sum)
    logic [7:0] m_a      = 8'h00;
    logic [7:0] m_b      = 8'h00;
    logic [8:0] last_res = 9'h000;
    int         m_cnt    = 0;
    int         b_edge   = -10;       // posedge index of the latest B transfer
    bit         accepted_flag = 1'b0;
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard: inputs are stable at the negedge, so each decision
    // here describes what the coming rising edge will do.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin : mon
        bit         valid_exp;
        bit         hs;
        bit         clr_hit;
        logic [8:0] popped;
        if (rst) begin
            started     = 1'b1;
            outstanding = 1'b0;
            have_a      = 1'b0;
            m_a         = 8'h00;
            m_b         = 8'h00;
            last_res    = 9'h000;
            m_cnt       = 0;
            accepted_flag = 1'b0;
            exp_q.delete();
        end else if (started) begin
            valid_exp = outstanding && (cyc >= b_edge + 1);
            chk("in_ready",  in_ready,  !outstanding);
            chk("busy",      busy,      outstanding || have_a);
            chk("en",        en,        outstanding && (cyc == b_edge));
            chk("res_valid", res_valid, valid_exp);
            chk("a",         a,         m_a);
            chk("b",         b,         m_b);
            chk("op_count",  op_count,  m_cnt);

            hs = valid_exp && res_ready;
            popped = last_res;
            if (hs) begin
                popped = exp_q.pop_front();
                chk("res_pop", res, popped);
                last_res = popped;
            end else begin
                chk("res", res, valid_exp ? exp_q[0] : last_res);
            end

            clr_hit = 1'b0;
`ifdef ACCUMULATE_EN
            clr_hit = clr && !outstanding;
            if (clr_hit) begin
                m_a    = 8'h00;
                have_a = 1'b0;
            end
`endif
            accepted_flag = 1'b0;
            if (!clr_hit && in_valid && !outstanding) begin
                accepted_flag = 1'b1;
                if (!have_a) begin
                    m_a    = in_data;
                    have_a = 1'b1;
                end else begin
                    m_b = in_data;
                    exp_q.push_back({1'b0, m_a} + {1'b0, in_data});
                    outstanding = 1'b1;
                    have_a      = 1'b0;
                    b_edge      = cyc + 1;
                end
            end

            if (hs) begin
                outstanding = 1'b0;
                m_cnt = (m_cnt + 1) % (1 << OPS_W);
`ifdef ACCUMULATE_EN
                m_a    = popped[7:0];
                have_a = 1'b1;
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] d);
        int g;
        in_valid = 1'b1;
        in_data  = d;
        g = 0;
        do begin
            @(posedge clk); #1;
            g++;
        end while (!accepted_flag && g < 200);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk("send_timeout", (g < 200), 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (outstanding && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("idle_timeout", (g < 200), 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : stim
        int g;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        clr       = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;

        // Basic add, carry and wrap cases
        send_byte(8'h12); send_byte(8'h34); wait_idle();
        send_byte(8'hFF); send_byte(8'h01); wait_idle();
        send_byte(8'h80); send_byte(8'h80); wait_idle();

        // Back-pressure with extra bytes offered on the bus
        res_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h22);
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (6) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        g = 0;
        do begin
            @(posedge clk); #1;
            g++;
        end while (!accepted_flag && g < 20);
        in_valid = 1'b0;
        chk("bp_accept_timeout", (g < 20), 1);
        send_byte(8'h01); wait_idle();

        // Reset with a partially loaded pair
        pulse_rst();
        send_byte(8'h55);
        pulse_rst();
        send_byte(8'h01); send_byte(8'h02); wait_idle();

`ifdef ACCUMULATE_EN
        pulse_rst();
        send_byte(8'h10); send_byte(8'h20); wait_idle();
        send_byte(8'h30); wait_idle();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        send_byte(8'h05); send_byte(8'h06); wait_idle();
        send_byte(8'hE5); wait_idle();
        send_byte(8'h20); wait_idle();
`endif

        // Randomized traffic, including back-pressure, clr and rare resets
        for (int i = 0; i < 2500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            res_ready = (($urandom % 4) != 0);
            clr       = (($urandom % 16) == 0);
            rst       = (($urandom % 400) == 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        clr       = 1'b0;
        rst       = 1'b0;
        res_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
